handshake_constant_check: RTL and testbench
===========================================

Name: handshake_constant_check

Overview:
- Consumer-side counterpart of a handshake constant source: terminates a data channel that should carry one fixed constant and re-emits one control token per accepted data token.
- Each emitted token carries a 1-bit match flag.
- Also keeps token/mismatch statistics and captures the first offending value for debug.
- Sits downstream of a constant source, or any producer of a constant, in the elastic dataflow netlist. It decouples ready paths with a 2-entry buffer.

Parameters:
- DATA_WIDTH, 32, width of the incoming data channel.
- EXPECTED, 17'h1EBE5 (125925), value every incoming token must equal. It is zero-extended or truncated to DATA_WIDTH.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ins  input  DATA_WIDTH  incoming data
- ins_valid  input  1  producer valid
- ins_ready  output  1  block can accept
- outs  output  1  match flag of the head token (1 = token equalled EXPECTED)
- outs_valid  output  1  control token available
- outs_ready  input  1  consumer ready
- tok_count  output  CNT_WIDTH  tokens accepted since reset
- bad_count  output  CNT_WIDTH  mismatching tokens accepted since reset
- mismatch  output  1  sticky: at least one mismatch seen
- first_bad  output  DATA_WIDTH  value of the first mismatching token

Behaviour:
- Clock and reset: one clock domain; all state is updated on the rising edge of clk.
- Reset: rst is synchronous and active-high. While rst=1 at an edge, the following are cleared:
  - occupancy := 0
  - both buffer slots := 0
  - tok_count := 0, bad_count := 0
  - mismatch := 0, first_bad := 0
- Outputs after reset: outs_valid=0, outs=0, ins_ready=1.
- Reset mid-operation: buffered tokens are discarded without being emitted. Any handshake in the reset cycle is ignored.
- Accept: push = ins_valid & ins_ready. Pop = outs_valid & outs_ready.
- ins_ready = (occupancy < 2). It depends only on registered state, never combinationally on outs_ready or ins_valid.
- Compare: match = (ins == EXPECTED[DATA_WIDTH-1:0]). This is evaluated combinationally on the push cycle, and the result is stored in the buffer.
- Buffer: 2-entry FIFO of 1-bit match flags, with occupancy 0..2.
  - outs_valid = (occupancy != 0).
  - outs = head flag. outs is 0 when the buffer is empty.
- Latency: a token pushed at edge N appears on outs_valid after edge N. That is 1 cycle, with no combinational path from ins to outs.
- Throughput: one token per cycle in steady state when the consumer is always ready.
- Buffer cases:
  - occ=0, push → occ=1; new entry becomes the head.
  - occ=1, push and pop together → occ stays 1; new entry becomes the head.
  - occ=1, pop only → occ=0.
  - occ=2 → ins_ready=0, so no push is possible; pop → occ=1 and the second entry becomes the head.
  - occ=2, no pop → hold; all outputs stable.
- Protocol: outs_valid and outs stay stable until the token is taken. The producer must hold ins and ins_valid stable until accepted; the block does not rely on this.
- Statistics, updated on each push:
  - tok_count += 1, saturating at all-ones.
  - If !match: bad_count += 1, saturating at all-ones.
  - If !match and mismatch=0: first_bad := ins, and mismatch := 1.
  - Later mismatches do not update first_bad. mismatch stays 1 until reset.
- No push in a cycle → statistics hold.

Test Plan:
- Reset then idle: assert rst for 2 cycles with ins_valid=0 → outs_valid=0, ins_ready=1, tok_count=0, bad_count=0, mismatch=0, first_bad=0.
- Streaming match: drive ins=0x0001EBE5 with ins_valid=1 for 10 cycles, outs_ready=1 → 10 tokens out, each outs=1. First outs_valid appears 1 cycle after the first push. tok_count=10, bad_count=0, mismatch=0.
- Backpressure: outs_ready=0, push 3 matching tokens → after 2 accepts ins_ready=0 and the third waits. Release outs_ready → the 2 buffered tokens drain in order, then the third is accepted. tok_count=3. No token is lost or duplicated.
- Mismatch capture: push in order 0x1EBE5, 0xDEADBEEF, 0x12345, 0x1EBE5 → outs sequence is 1,0,0,1. bad_count=2, mismatch=1, first_bad=0xDEADBEEF.
- Simultaneous push/pop at occ=1: alternate tokens 0x1EBE5 and 0x0 with both sides ready for 8 cycles → occupancy stays 1, outs alternates 1,0 one cycle after each input, ins_ready stays 1.
- Reset mid-operation: with occ=2 and mismatch=1, pulse rst for 1 cycle → next cycle outs_valid=0, all counters 0, mismatch=0. The first token after reset with ins=0x1EBE5 produces outs=1 and tok_count=1.

Source files
------------

// File: rtl/handshake_constant_check.sv
// Consumer for a channel that should carry one fixed constant. Each accepted
// token becomes a 1-bit match flag in a 2-entry elastic buffer, and the block
// keeps token and mismatch statistics.
module handshake_constant_check #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] EXPECTED   = DATA_WIDTH'(17'h1EBE5),
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic [CNT_WIDTH-1:0]  tok_count,
   output logic [CNT_WIDTH-1:0]  bad_count,
   output logic                  mismatch,
   output logic [DATA_WIDTH-1:0] first_bad
);

   typedef enum logic [1:0] {
      OccEmpty = 2'd0,
      OccOne   = 2'd1,
      OccTwo   = 2'd2
   } occ_t;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   occ_t                  occ_q, occ_d;
   logic                  slot0_q, slot0_d;
   logic                  slot1_q, slot1_d;
   logic [CNT_WIDTH-1:0]  tokCount_q, tokCount_d;
   logic [CNT_WIDTH-1:0]  badCount_q, badCount_d;
   logic                  mismatch_q, mismatch_d;
   logic [DATA_WIDTH-1:0] firstBad_q, firstBad_d;

   logic push;
   logic pop;
   logic match;

   // Ready comes only from registered occupancy, so no combinational ready path exists.
   assign ins_ready  = (occ_q != OccTwo);
   assign outs_valid = (occ_q != OccEmpty);
   assign outs       = outs_valid & slot0_q;

   assign push  = ins_valid & ins_ready;
   assign pop   = outs_valid & outs_ready;
   assign match = (ins == EXPECTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= OccEmpty;
         slot0_q    <= 1'b0;
         slot1_q    <= 1'b0;
         tokCount_q <= '0;
         badCount_q <= '0;
         mismatch_q <= 1'b0;
         firstBad_q <= '0;
      end else begin
         occ_q      <= occ_d;
         slot0_q    <= slot0_d;
         slot1_q    <= slot1_d;
         tokCount_q <= tokCount_d;
         badCount_q <= badCount_d;
         mismatch_q <= mismatch_d;
         firstBad_q <= firstBad_d;
      end
   end

   // slot0 is always the head; emptied slots are cleared so stale flags never linger.
   always_comb begin
      occ_d   = occ_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case (occ_q)
         OccEmpty: begin
            if (push) begin
               occ_d   = OccOne;
               slot0_d = match;
            end
         end
         OccOne: begin
            if (push && pop) begin
               slot0_d = match;
            end else if (push) begin
               occ_d   = OccTwo;
               slot1_d = match;
            end else if (pop) begin
               occ_d   = OccEmpty;
               slot0_d = 1'b0;
            end
         end
         OccTwo: begin
            if (pop) begin
               occ_d   = OccOne;
               slot0_d = slot1_q;
               slot1_d = 1'b0;
            end
         end
         default: begin
            occ_d   = OccEmpty;
            slot0_d = 1'b0;
            slot1_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      tokCount_d = tokCount_q;
      badCount_d = badCount_q;
      mismatch_d = mismatch_q;
      firstBad_d = firstBad_q;
      if (push) begin
         if (tokCount_q != CntMax) begin
            tokCount_d = tokCount_q + CntOne;
         end
         if (!match) begin
            if (badCount_q != CntMax) begin
               badCount_d = badCount_q + CntOne;
            end
            // Only the first offending value is kept for debug.
            if (!mismatch_q) begin
               firstBad_d = ins;
               mismatch_d = 1'b1;
            end
         end
      end
   end

   assign tok_count = tokCount_q;
   assign bad_count = badCount_q;
   assign mismatch  = mismatch_q;
   assign first_bad = firstBad_q;

endmodule

// File: tb/tb_handshake_constant_check.sv
// Directed bench for handshake_constant_check: reset, streaming, backpressure,
// mismatch capture, simultaneous push/pop and reset while busy.
module tb_handshake_constant_check;

   logic        clk;
   logic        rst;
   logic [31:0] ins;
   logic        ins_valid;
   logic        ins_ready;
   logic        outs;
   logic        outs_valid;
   logic        outs_ready;
   logic [15:0] tok_count;
   logic [15:0] bad_count;
   logic        mismatch;
   logic [31:0] first_bad;

   int checks;
   int errors;

   localparam logic [31:0] Good = 32'h0001_EBE5;

   handshake_constant_check dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .tok_count  (tok_count),
      .bad_count  (bad_count),
      .mismatch   (mismatch),
      .first_bad  (first_bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
      ins_valid  = v;
      ins        = d;
      outs_ready = r;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);

      // Reset then idle
      tick();
      tick();
      checkOutput("rst_outs_valid", {31'b0, outs_valid}, 32'd0);
      checkOutput("rst_outs", {31'b0, outs}, 32'd0);
      checkOutput("rst_ins_ready", {31'b0, ins_ready}, 32'd1);
      checkOutput("rst_tok", {16'b0, tok_count}, 32'd0);
      checkOutput("rst_bad", {16'b0, bad_count}, 32'd0);
      checkOutput("rst_mismatch", {31'b0, mismatch}, 32'd0);
      checkOutput("rst_first_bad", first_bad, 32'd0);
      rst = 1'b0;
      tick();

      // Streaming match: 10 tokens, consumer always ready
      applyStimulus(1'b1, Good, 1'b1);
      #1;
      checkOutput("stream_no_comb_path", {31'b0, outs_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("stream_valid", {31'b0, outs_valid}, 32'd1);
         checkOutput("stream_outs", {31'b0, outs}, 32'd1);
         checkOutput("stream_tok", {16'b0, tok_count}, 32'(i + 1));
         checkOutput("stream_ready", {31'b0, ins_ready}, 32'd1);
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("stream_drained", {31'b0, outs_valid}, 32'd0);
      checkOutput("stream_empty_outs", {31'b0, outs}, 32'd0);
      checkOutput("stream_tok_end", {16'b0, tok_count}, 32'd10);
      checkOutput("stream_bad_end", {16'b0, bad_count}, 32'd0);
      checkOutput("stream_mismatch_end", {31'b0, mismatch}, 32'd0);

      // Backpressure: three tokens offered while consumer stalls
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, Good, 1'b0);
      tick();
      checkOutput("bp_ready_occ1", {31'b0, ins_ready}, 32'd1);
      checkOutput("bp_tok1", {16'b0, tok_count}, 32'd1);
      tick();
      checkOutput("bp_ready_occ2", {31'b0, ins_ready}, 32'd0);
      checkOutput("bp_tok2", {16'b0, tok_count}, 32'd2);
      tick();
      checkOutput("bp_hold_ready", {31'b0, ins_ready}, 32'd0);
      checkOutput("bp_hold_tok", {16'b0, tok_count}, 32'd2);
      checkOutput("bp_hold_valid", {31'b0, outs_valid}, 32'd1);
      checkOutput("bp_hold_outs", {31'b0, outs}, 32'd1);
      applyStimulus(1'b1, Good, 1'b1);
      tick();
      checkOutput("bp_pop1_ready", {31'b0, ins_ready}, 32'd1);
      checkOutput("bp_pop1_tok", {16'b0, tok_count}, 32'd2);
      checkOutput("bp_pop1_valid", {31'b0, outs_valid}, 32'd1);
      tick();
      checkOutput("bp_third_tok", {16'b0, tok_count}, 32'd3);
      checkOutput("bp_third_valid", {31'b0, outs_valid}, 32'd1);
      checkOutput("bp_third_ready", {31'b0, ins_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("bp_drained", {31'b0, outs_valid}, 32'd0);
      checkOutput("bp_tok_end", {16'b0, tok_count}, 32'd3);

      // Mismatch capture
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, Good, 1'b1);
      tick();
      checkOutput("mm_outs0", {31'b0, outs}, 32'd1);
      checkOutput("mm_sticky0", {31'b0, mismatch}, 32'd0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
      tick();
      checkOutput("mm_outs1", {31'b0, outs}, 32'd0);
      checkOutput("mm_first_bad1", first_bad, 32'hDEAD_BEEF);
      checkOutput("mm_sticky1", {31'b0, mismatch}, 32'd1);
      applyStimulus(1'b1, 32'h0001_2345, 1'b1);
      tick();
      checkOutput("mm_outs2", {31'b0, outs}, 32'd0);
      checkOutput("mm_first_bad2", first_bad, 32'hDEAD_BEEF);
      applyStimulus(1'b1, Good, 1'b1);
      tick();
      checkOutput("mm_outs3", {31'b0, outs}, 32'd1);
      checkOutput("mm_bad", {16'b0, bad_count}, 32'd2);
      checkOutput("mm_tok", {16'b0, tok_count}, 32'd4);
      checkOutput("mm_sticky3", {31'b0, mismatch}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("mm_drained", {31'b0, outs_valid}, 32'd0);

      // Simultaneous push/pop with alternating match/mismatch
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? Good : 32'h0, 1'b1);
         tick();
         checkOutput("pp_valid", {31'b0, outs_valid}, 32'd1);
         checkOutput("pp_outs", {31'b0, outs}, (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("pp_ready", {31'b0, ins_ready}, 32'd1);
      end
      checkOutput("pp_tok", {16'b0, tok_count}, 32'd12);
      checkOutput("pp_bad", {16'b0, bad_count}, 32'd6);
      checkOutput("pp_first_bad", first_bad, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("pp_drained", {31'b0, outs_valid}, 32'd0);

      // Reset while full with a mismatch recorded
      applyStimulus(1'b1, 32'h0000_0005, 1'b0);
      tick();
      tick();
      checkOutput("mr_full_ready", {31'b0, ins_ready}, 32'd0);
      checkOutput("mr_full_bad", {16'b0, bad_count}, 32'd8);
      checkOutput("mr_full_first_bad", first_bad, 32'hDEAD_BEEF);
      rst = 1'b1;
      applyStimulus(1'b1, Good, 1'b1);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("mr_valid", {31'b0, outs_valid}, 32'd0);
      checkOutput("mr_outs", {31'b0, outs}, 32'd0);
      checkOutput("mr_ready", {31'b0, ins_ready}, 32'd1);
      checkOutput("mr_tok", {16'b0, tok_count}, 32'd0);
      checkOutput("mr_bad", {16'b0, bad_count}, 32'd0);
      checkOutput("mr_mismatch", {31'b0, mismatch}, 32'd0);
      checkOutput("mr_first_bad", first_bad, 32'd0);
      applyStimulus(1'b1, Good, 1'b1);
      tick();
      checkOutput("mr_post_valid", {31'b0, outs_valid}, 32'd1);
      checkOutput("mr_post_outs", {31'b0, outs}, 32'd1);
      checkOutput("mr_post_tok", {16'b0, tok_count}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
